input_mems: RTL and testbench
=============================

# input_mems

Input-side staging block for the 2D convolution accelerator. It receives one AXI-Stream packet per convolution: an optional weight matrix W (K×K), an optional bias word B, then a full R×C input matrix X. Each packet is stored in local dual-port memories built from `memory_dual_port`. Once a packet is stored, the block signals the compute engine, serves its random-access reads, and refuses new input until the compute engine reports completion. It is the receiving counterpart of `fifo_out` on the accelerator's output side.

## Interface
- INW, 24, width of every stream word, weight, bias and X entry.
- R, 9, rows of X.
- C, 8, columns of X.
- MAXK, 4, largest supported K.
- K_BITS, $clog2(MAXK+1), width of K (localparam).
- X_ADDR_BITS, $clog2(R*C), X address width (localparam).
- W_ADDR_BITS, $clog2(MAXK*MAXK), W address width (localparam).

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- AXIS_TDATA  in  INW  stream data word.
- AXIS_TVALID  in  1  producer has a valid word.
- AXIS_TUSER  in  K_BITS+1  bit 0 is new_W; bits K_BITS:1 are K. Sampled on the first word of a packet only.
- AXIS_TREADY  out  1  block accepts the word this cycle.
- inputs_loaded  out  1  a complete packet is stored; memories are valid for reading.
- compute_finished  in  1  pulse from the compute engine; releases the stored packet.
- K  out  K_BITS  current filter size.
- B  out  INW  current bias word.
- X_read_addr  in  X_ADDR_BITS  row-major X index.
- X_data  out  INW  X word, 1-cycle read latency.
- W_read_addr  in  W_ADDR_BITS  row-major W index (r*K+c).
- W_data  out  INW  W word, 1-cycle read latency.

## Operation
- A handshake occurs in any cycle where AXIS_TVALID=1 and AXIS_TREADY=1. Each handshake writes exactly one word.
- States:
  - IDLE: waiting for the first word of a packet.
  - LOAD_W: receiving weights.
  - LOAD_B: receiving the bias word (macro only).
  - LOAD_X: receiving X.
  - DONE: packet stored, held for the compute engine.
- IDLE, first handshake:
  - Latch new_W = TUSER[0].
  - If new_W=1: latch K = TUSER[K_BITS:1]; the word is W[0].
  - If new_W=0: the word is X[0]; K, B and the W memory keep their previous contents.
- LOAD_W:
  - Weights are written at W address 0..K*K-1 in order.
  - After the handshake at address K*K-1, go to LOAD_B if the macro is defined, else to LOAD_X.
  - K=1 with new_W=1: the IDLE word is also the last weight; go directly to LOAD_B or LOAD_X.
- LOAD_B: exactly one handshake; it stores B, then go to LOAD_X.
- LOAD_X:
  - X words are written at X address 0..R*C-1 in order.
  - After the handshake at R*C-1, go to DONE.
- DONE:
  - AXIS_TREADY=0 and inputs_loaded=1.
  - compute_finished=1 returns the FSM to IDLE.
  - compute_finished in any other state is ignored.
- Illegal input, with unspecified behaviour:
  - new_W=1 with K=0 or K>MAXK.
  - new_W=0 as the first packet after reset. K reads 0 and W contents are undefined.
- TUSER on any word after the first is ignored.
- Write counters are W_ADDR_BITS and X_ADDR_BITS wide and clear to 0 on entry to IDLE.
- The K*K comparison uses a product at least 2*K_BITS wide.
- Reads are never gated; X_data and W_data follow their addresses in all states. Contents are only guaranteed while inputs_loaded=1.

## Timing
- Reset values:
  - FSM in IDLE.
  - AXIS_TREADY=1, inputs_loaded=0, K=0, B=0, counters 0.
  - Memory contents are not cleared.
- AXIS_TREADY is decoded from the registered state only; there is no combinational path from TVALID. It is 1 in IDLE, LOAD_W, LOAD_B and LOAD_X.
- Full throughput is one word per cycle. Words per packet:
  - new_W=1: K*K + (1 if macro) + R*C.
  - new_W=0: R*C.
- Memory writes occur at the clock edge of the handshake. A read of that address issued the next cycle returns the new word one cycle later.
- inputs_loaded rises the cycle after the last X handshake.
- With compute_finished sampled high at edge n:
  - inputs_loaded=0 and AXIS_TREADY=1 from cycle n+1.
  - The first word of the next packet can be accepted at cycle n+1.
- Reset mid-packet aborts the load and returns the FSM to IDLE. The partial data is discarded, and the next packet starts at address 0.

## Configuration
- INPUT_MEMS_BIAS_EN defined:
  - When new_W=1, one bias word follows the weights (LOAD_B state).
  - B holds the bias until the next new_W=1 packet or reset.
- INPUT_MEMS_BIAS_EN undefined:
  - There is no LOAD_B state; X follows the weights directly.
  - B is constant 0.

## Test plan
- Weights then X, TVALID held high: reset, then new_W=1, K=3, weights 1..9, X 100..171.
  - TREADY=1 for all 81 handshakes.
  - inputs_loaded rises the cycle after handshake 81.
  - W_read_addr=4 gives W_data=5 one cycle later; X_read_addr=71 gives X_data=171.
- X only: a second packet with new_W=0 and X 200..271.
  - K stays 3 and W_read_addr=8 still returns 9.
  - X_read_addr=0 returns 200.
- Random 50% TVALID gaps, plus words offered during DONE.
  - Memory contents match scenario 1.
  - TREADY=0 throughout DONE, and no word is accepted there.
- compute_finished ordering:
  - A pulse during LOAD_X has no effect.
  - A pulse in DONE drops inputs_loaded and raises TREADY next cycle; a back-to-back packet is accepted immediately.
- Reset after 30 X handshakes:
  - Next cycle: TREADY=1, inputs_loaded=0, K=0.
  - A fresh new_W=1, K=2 packet then loads correctly.
- Macro on, new_W=1, K=2, words 1..4, then -7, then X 10..81:
  - B=-7.
  - X_read_addr=0 gives 10.
  - The same stimulus with the macro off stores -7 as X[0].

Source files
------------

// File: rtl/input_mems.sv
// ---------------------------------------------------------------------------
// input_mems : input-side staging block for the 2D convolution accelerator.
//
// Receives one AXI-Stream packet per convolution (optional K x K weights,
// optional bias word, then the full R x C input matrix X). The packet is
// stored in two dual-port memories. inputs_loaded is raised and the packet
// is held until the compute engine pulses compute_finished.
//
// Build option:
//   INPUT_MEMS_BIAS_EN - when defined, a packet that carries new weights
//                        also carries one bias word right after the
//                        weights. When undefined, B is constant 0.
//
// Stream handshake: a word is transferred on every rising clk edge where
// AXIS_TVALID and AXIS_TREADY are both 1. AXIS_TREADY is driven from a
// register only, so it never depends combinationally on AXIS_TVALID. The
// producer may raise or drop TVALID at any cycle boundary.
//
// The FSM state is visible on dbg_state_o for checkers and debug.
// ---------------------------------------------------------------------------

// Simple dual-port RAM: one synchronous write port, one registered read port.
// A write and a read of the same address in the same cycle returns the old
// word.
module memory_dual_port #(
    parameter int WIDTH     = 24,
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write on the handshake edge; read is always enabled with 1-cycle latency.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

module input_mems #(
    parameter  int INW         = 24,
    parameter  int R           = 9,
    parameter  int C           = 8,
    parameter  int MAXK        = 4,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int X_ADDR_BITS = $clog2(R * C),
    localparam int W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
    input  logic                   clk,
    input  logic                   reset,
    // Input stream
    input  logic [INW-1:0]         AXIS_TDATA,
    input  logic                   AXIS_TVALID,
    input  logic [K_BITS:0]        AXIS_TUSER,
    output logic                   AXIS_TREADY,
    // Compute engine side
    output logic                   inputs_loaded,
    input  logic                   compute_finished,
    output logic [K_BITS-1:0]      K,
    output logic [INW-1:0]         B,
    input  logic [X_ADDR_BITS-1:0] X_read_addr,
    output logic [INW-1:0]         X_data,
    input  logic [W_ADDR_BITS-1:0] W_read_addr,
    output logic [INW-1:0]         W_data,
    // Debug
    output logic [2:0]             dbg_state_o
);

    // Wide enough to hold MAXK*MAXK without overflow.
    localparam int PROD_BITS = 2 * K_BITS;
    localparam logic [X_ADDR_BITS-1:0] X_LAST = X_ADDR_BITS'(R * C - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_LOAD_B = 3'd2,
        S_LOAD_X = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // State entered after the last weight has been written.
`ifdef INPUT_MEMS_BIAS_EN
    localparam state_t AFTER_W = S_LOAD_B;
`else
    localparam state_t AFTER_W = S_LOAD_X;
`endif

    state_t                 state_q;
    logic                   tready_q;
    logic                   loaded_q;
    logic [W_ADDR_BITS-1:0] w_cnt_q;
    logic [X_ADDR_BITS-1:0] x_cnt_q;
    logic [K_BITS-1:0]      k_q;
`ifdef INPUT_MEMS_BIAS_EN
    logic [INW-1:0]         b_q;
`endif

    logic                   hs;
    logic                   tuser_new_w;
    logic [K_BITS-1:0]      tuser_k;
    logic [PROD_BITS-1:0]   kk_last;
    logic                   w_last;
    logic                   x_last;

    logic                   w_we;
    logic [W_ADDR_BITS-1:0] w_waddr;
    logic                   x_we;
    logic [X_ADDR_BITS-1:0] x_waddr;

    assign hs          = AXIS_TVALID && tready_q;
    assign tuser_new_w = AXIS_TUSER[0];
    assign tuser_k     = AXIS_TUSER[K_BITS:1];

    // Index of the last weight (K*K-1), computed on the latched K.
    assign kk_last = PROD_BITS'(k_q) * PROD_BITS'(k_q) - PROD_BITS'(1);
    assign w_last  = (PROD_BITS'(w_cnt_q) == kk_last);
    assign x_last  = (x_cnt_q == X_LAST);

    // Memory write ports: the first word of a packet always lands at
    // address 0 of whichever memory the new_W flag selects.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_cnt_q;
        x_we    = 1'b0;
        x_waddr = x_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    if (tuser_new_w) begin
                        w_we    = 1'b1;
                        w_waddr = '0;
                    end else begin
                        x_we    = 1'b1;
                        x_waddr = '0;
                    end
                end
            end
            S_LOAD_W: w_we = hs;
            S_LOAD_X: x_we = hs;
            default: begin
                w_we = 1'b0;
                x_we = 1'b0;
            end
        endcase
    end

    // Packet-load FSM with registered TREADY / inputs_loaded, counters and
    // the latched K (and bias when enabled).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tready_q <= 1'b1;
            loaded_q <= 1'b0;
            w_cnt_q  <= '0;
            x_cnt_q  <= '0;
            k_q      <= '0;
`ifdef INPUT_MEMS_BIAS_EN
            b_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hs) begin
                        if (tuser_new_w) begin
                            k_q <= tuser_k;
                            if (tuser_k == K_BITS'(1)) begin
                                // The single weight was this word.
                                state_q <= AFTER_W;
                                w_cnt_q <= '0;
                            end else begin
                                state_q <= S_LOAD_W;
                                w_cnt_q <= W_ADDR_BITS'(1);
                            end
                        end else if (x_last) begin
                            // Degenerate 1-element X: the packet is complete.
                            state_q  <= S_DONE;
                            tready_q <= 1'b0;
                            loaded_q <= 1'b1;
                        end else begin
                            state_q <= S_LOAD_X;
                            x_cnt_q <= X_ADDR_BITS'(1);
                        end
                    end
                end

                S_LOAD_W: begin
                    if (hs) begin
                        if (w_last) begin
                            state_q <= AFTER_W;
                            w_cnt_q <= '0;
                        end else begin
                            w_cnt_q <= w_cnt_q + W_ADDR_BITS'(1);
                        end
                    end
                end

`ifdef INPUT_MEMS_BIAS_EN
                S_LOAD_B: begin
                    if (hs) begin
                        b_q     <= AXIS_TDATA;
                        state_q <= S_LOAD_X;
                    end
                end
`endif

                S_LOAD_X: begin
                    if (hs) begin
                        if (x_last) begin
                            state_q  <= S_DONE;
                            tready_q <= 1'b0;
                            loaded_q <= 1'b1;
                        end else begin
                            x_cnt_q <= x_cnt_q + X_ADDR_BITS'(1);
                        end
                    end
                end

                S_DONE: begin
                    // Hold the packet until the compute engine releases it.
                    if (compute_finished) begin
                        state_q  <= S_IDLE;
                        tready_q <= 1'b1;
                        loaded_q <= 1'b0;
                        w_cnt_q  <= '0;
                        x_cnt_q  <= '0;
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    tready_q <= 1'b1;
                    loaded_q <= 1'b0;
                    w_cnt_q  <= '0;
                    x_cnt_q  <= '0;
                end
            endcase
        end
    end

    memory_dual_port #(
        .WIDTH     (INW),
        .DEPTH     (MAXK * MAXK),
        .ADDR_BITS (W_ADDR_BITS)
    ) u_w_mem (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i (w_waddr),
        .wdata_i (AXIS_TDATA),
        .raddr_i (W_read_addr),
        .rdata_o (W_data)
    );

    memory_dual_port #(
        .WIDTH     (INW),
        .DEPTH     (R * C),
        .ADDR_BITS (X_ADDR_BITS)
    ) u_x_mem (
        .clk     (clk),
        .we_i    (x_we),
        .waddr_i (x_waddr),
        .wdata_i (AXIS_TDATA),
        .raddr_i (X_read_addr),
        .rdata_o (X_data)
    );

    assign AXIS_TREADY   = tready_q;
    assign inputs_loaded = loaded_q;
    assign K             = k_q;
`ifdef INPUT_MEMS_BIAS_EN
    assign B             = b_q;
`else
    assign B             = '0;
`endif
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_input_mems.sv
// Bench for input_mems: directed packets, table-driven memory read checks,
// hand-written sequences for release, back-to-back, DONE back-pressure,
// mid-packet reset and the optional bias word.
`timescale 1ns/1ps
module tb_input_mems;
  localparam int INW         = 24;
  localparam int R           = 9;
  localparam int C           = 8;
  localparam int MAXK        = 4;
  localparam int K_BITS      = 3;
  localparam int X_ADDR_BITS = 7;
  localparam int W_ADDR_BITS = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [INW-1:0]         AXIS_TDATA;
  logic                   AXIS_TVALID;
  logic [K_BITS:0]        AXIS_TUSER;
  logic                   AXIS_TREADY;
  logic                   inputs_loaded;
  logic                   compute_finished;
  logic [K_BITS-1:0]      K;
  logic [INW-1:0]         B;
  logic [X_ADDR_BITS-1:0] X_read_addr;
  logic [INW-1:0]         X_data;
  logic [W_ADDR_BITS-1:0] W_read_addr;
  logic [INW-1:0]         W_data;
  logic [2:0]             dbg_state_o;

  input_mems #(.INW(INW), .R(R), .C(C), .MAXK(MAXK)) dut (
    .clk              (clk),
    .reset            (reset),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TVALID      (AXIS_TVALID),
    .AXIS_TUSER       (AXIS_TUSER),
    .AXIS_TREADY      (AXIS_TREADY),
    .inputs_loaded    (inputs_loaded),
    .compute_finished (compute_finished),
    .K                (K),
    .B                (B),
    .X_read_addr      (X_read_addr),
    .X_data           (X_data),
    .W_read_addr      (W_read_addr),
    .W_data           (W_data),
    .dbg_state_o      (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2ms required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    bit             is_x;
    int             addr;
    logic [INW-1:0] exp;
  } rd_vec_t;

  rd_vec_t          tab[$];
  logic [INW-1:0]   exp_q[$];
  int               n_cmp = 0;
  int               n_fail = 0;
  int               hs_cnt = 0;
  int               done_ready_cnt = 0;
  int               done_hs_cnt = 0;
  int               stall_cnt = 0;

  // Independent observers of the handshake and of back-pressure in DONE.
  always @(posedge clk) begin
    if (!reset) begin
      if (AXIS_TVALID && AXIS_TREADY) hs_cnt++;
      if (inputs_loaded && AXIS_TREADY) done_ready_cnt++;
      if (inputs_loaded && AXIS_TVALID && AXIS_TREADY) done_hs_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [INW-1:0] d, input logic [K_BITS:0] u,
                           input int gap, input bit cf);
    int waited;
    waited = 0;
    repeat (gap) begin
      @(negedge clk);
      AXIS_TVALID      = 1'b0;
      compute_finished = 1'b0;
    end
    @(negedge clk);
    AXIS_TDATA       = d;
    AXIS_TUSER       = u;
    AXIS_TVALID      = 1'b1;
    compute_finished = cf;
    if (!AXIS_TREADY) stall_cnt++;
    while (!AXIS_TREADY && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!AXIS_TREADY) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake_timeout: got TREADY=0 for 200 cycles required 1");
      AXIS_TVALID = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    AXIS_TVALID      = 1'b0;
    compute_finished = 1'b0;
  endtask

  function automatic logic [K_BITS:0] junk_user();
    return (K_BITS+1)'($urandom_range(0, 15));
  endfunction

  function automatic int pick_gap(input int gap_max);
    return (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
  endfunction

  // One packet: weights w_first.., optional bias, X x_first.. (nx words).
  task automatic send_packet(input bit new_w, input int k, input int w_first,
                             input logic [INW-1:0] bias, input int x_first,
                             input int nx, input int gap_max);
    logic [K_BITS:0] u0;
    bit              first;
    u0    = {K_BITS'(k), new_w};
    first = 1'b1;
    if (new_w) begin
      for (int i = 0; i < k * k; i++) begin
        send_word(INW'(w_first + i), first ? u0 : junk_user(), pick_gap(gap_max), 1'b0);
        first = 1'b0;
      end
`ifdef INPUT_MEMS_BIAS_EN
      send_word(bias, junk_user(), pick_gap(gap_max), 1'b0);
`endif
    end
    for (int i = 0; i < nx; i++) begin
      send_word(INW'(x_first + i), first ? u0 : junk_user(), pick_gap(gap_max), 1'b0);
      first = 1'b0;
    end
  endtask

  task automatic release_done();
    @(negedge clk);
    compute_finished = 1'b1;
    @(negedge clk);
    compute_finished = 1'b0;
  endtask

  task automatic rd(input bit is_x, input int addr, output logic [INW-1:0] v);
    @(negedge clk);
    if (is_x) X_read_addr = X_ADDR_BITS'(addr);
    else      W_read_addr = W_ADDR_BITS'(addr);
    @(negedge clk);
    v = is_x ? X_data : W_data;
  endtask

  task automatic add_rd(input bit is_x, input int addr, input logic [INW-1:0] exp);
    rd_vec_t r;
    r.is_x = is_x;
    r.addr = addr;
    r.exp  = exp;
    tab.push_back(r);
  endtask

  // Apply every entry of the read table and compare.
  task automatic run_table(input string tag);
    logic [INW-1:0] v;
    for (int i = 0; i < tab.size(); i++) begin
      rd(tab[i].is_x, tab[i].addr, v);
      check($sformatf("%s_%s[%0d]", tag, tab[i].is_x ? "X" : "W", tab[i].addr),
            32'(v), 32'(tab[i].exp));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int             hs0;
    logic [INW-1:0] v;

    reset            = 1'b1;
    AXIS_TDATA       = '0;
    AXIS_TVALID      = 1'b0;
    AXIS_TUSER       = '0;
    compute_finished = 1'b0;
    X_read_addr      = '0;
    W_read_addr      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_tready", 32'(AXIS_TREADY), 32'd1);
    check("rst_loaded", 32'(inputs_loaded), 32'd0);
    check("rst_K", 32'(K), 32'd0);
    check("rst_B", 32'(B), 32'd0);

    // Read table for the weights 1..9 / X 100..171 packet.
    tab.delete();
    add_rd(1'b0, 4, 24'd5);
    add_rd(1'b0, 0, 24'd1);
    add_rd(1'b0, 8, 24'd9);
    add_rd(1'b1, 71, 24'd171);
    add_rd(1'b1, 0, 24'd100);
    add_rd(1'b1, 35, 24'd135);

    // Packet 1: K=3, weights 1..9, X 100..171, TVALID held high
    hs0 = hs_cnt;
    stall_cnt = 0;
    send_packet(1'b1, 3, 1, 24'h0000B5, 100, 72, 0);
    idle();
    check("p1_loaded_after_last", 32'(inputs_loaded), 32'd1);
    check("p1_tready_done", 32'(AXIS_TREADY), 32'd0);
    check("p1_stalls", 32'(stall_cnt), 32'd0);
`ifdef INPUT_MEMS_BIAS_EN
    check("p1_hs_count", 32'(hs_cnt - hs0), 32'd82);
    check("p1_B", 32'(B), 32'h0000B5);
`else
    check("p1_hs_count", 32'(hs_cnt - hs0), 32'd81);
    check("p1_B", 32'(B), 32'd0);
`endif
    check("p1_K", 32'(K), 32'd3);
    run_table("p1");

    // Release in DONE, then a back-to-back X-only packet with a
    // compute_finished pulse during LOAD_X.
    @(negedge clk);
    compute_finished = 1'b1;
    @(negedge clk);
    compute_finished = 1'b0;
    check("rel_loaded", 32'(inputs_loaded), 32'd0);
    check("rel_tready", 32'(AXIS_TREADY), 32'd1);
    hs0 = hs_cnt;
    AXIS_TDATA  = 24'd200;
    AXIS_TUSER  = {K_BITS'(0), 1'b0};
    AXIS_TVALID = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_first_accepted", 32'(hs_cnt - hs0), 32'd1);
    for (int i = 1; i < 72; i++) begin
      send_word(INW'(200 + i), junk_user(), 0, i == 20);
    end
    idle();
    check("p2_loaded", 32'(inputs_loaded), 32'd1);
    check("p2_hs_count", 32'(hs_cnt - hs0), 32'd72);
    check("p2_K", 32'(K), 32'd3);
    tab.delete();
    add_rd(1'b0, 8, 24'd9);
    add_rd(1'b1, 0, 24'd200);
    add_rd(1'b1, 71, 24'd271);
    add_rd(1'b1, 20, 24'd220);
    run_table("p2");

    // Words offered during DONE must not be accepted.
    hs0 = hs_cnt;
    @(negedge clk);
    AXIS_TDATA  = 24'hABCDEF;
    AXIS_TUSER  = {K_BITS'(0), 1'b0};
    AXIS_TVALID = 1'b1;
    repeat (5) @(negedge clk);
    AXIS_TVALID = 1'b0;
    check("done_no_accept", 32'(hs_cnt - hs0), 32'd0);
    rd(1'b1, 0, v);
    check("done_X0_kept", 32'(v), 32'd200);

    // Packet 1 again with random TVALID gaps.
    release_done();
    hs0 = hs_cnt;
    send_packet(1'b1, 3, 1, 24'h0000B5, 100, 72, 1);
    idle();
    check("gap_loaded", 32'(inputs_loaded), 32'd1);
`ifdef INPUT_MEMS_BIAS_EN
    check("gap_hs_count", 32'(hs_cnt - hs0), 32'd82);
`else
    check("gap_hs_count", 32'(hs_cnt - hs0), 32'd81);
`endif
    tab.delete();
    add_rd(1'b0, 4, 24'd5);
    add_rd(1'b0, 7, 24'd8);
    add_rd(1'b1, 71, 24'd171);
    add_rd(1'b1, 0, 24'd100);
    run_table("gap");

    // Reset after 30 X handshakes, then a fresh K=2 packet.
    release_done();
    send_packet(1'b0, 0, 0, 24'd0, 300, 30, 0);
    @(negedge clk);
    AXIS_TVALID = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_tready", 32'(AXIS_TREADY), 32'd1);
    check("mid_rst_loaded", 32'(inputs_loaded), 32'd0);
    check("mid_rst_K", 32'(K), 32'd0);
    send_packet(1'b1, 2, 11, 24'h000055, 400, 72, 0);
    idle();
    check("k2_loaded", 32'(inputs_loaded), 32'd1);
    check("k2_K", 32'(K), 32'd2);
`ifdef INPUT_MEMS_BIAS_EN
    check("k2_B", 32'(B), 32'h000055);
`else
    check("k2_B", 32'(B), 32'd0);
`endif
    tab.delete();
    add_rd(1'b0, 0, 24'd11);
    add_rd(1'b0, 3, 24'd14);
    add_rd(1'b1, 0, 24'd400);
    add_rd(1'b1, 71, 24'd471);
    run_table("k2");

    // Bias stream: K=2 weights 1..4, then -7, then X 10..81.
    release_done();
    exp_q.delete();
    for (int i = 1; i <= 4; i++) exp_q.push_back(INW'(i));
    exp_q.push_back(24'hFFFFF9);
    for (int i = 10; i <= 80; i++) exp_q.push_back(INW'(i));
`ifdef INPUT_MEMS_BIAS_EN
    exp_q.push_back(24'd81);
`endif
    for (int i = 0; i < exp_q.size(); i++) begin
      send_word(exp_q[i], (i == 0) ? {K_BITS'(2), 1'b1} : junk_user(), 0, 1'b0);
    end
    idle();
    check("bias_loaded", 32'(inputs_loaded), 32'd1);
    rd(1'b1, 0, v);
`ifdef INPUT_MEMS_BIAS_EN
    check("bias_B", 32'(B), 32'hFFFFF9);
    check("bias_X0", 32'(v), 32'd10);
    rd(1'b1, 71, v);
    check("bias_X71", 32'(v), 32'd81);
`else
    check("bias_B", 32'(B), 32'd0);
    check("bias_X0", 32'(v), 32'hFFFFF9);
    rd(1'b1, 71, v);
    check("bias_X71", 32'(v), 32'd80);
`endif
    rd(1'b0, 3, v);
    check("bias_W3", 32'(v), 32'd4);

    // Whole-run back-pressure observations.
    check("done_tready_cycles", 32'(done_ready_cnt), 32'd0);
    check("done_handshakes", 32'(done_hs_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
